fifo_channel_batch_reader: RTL and testbench
============================================

// Module: fifo_channel_batch_reader
// PURPOSE
//  Consumer end of an async FIFO channel's pop side (non-showahead: pop_valid/pop_data 1 cycle after accepted pop).
//  Gathers entries into batches of BATCH_SIZE, or a partial batch on timeout/flush.
//  Drives pop_enable under credit control and re-emits words on a valid/ready stream with a batch-last tag.
//  Sits in the channel's read clock domain, between the channel and the RPC/packet consumer logic.
// PARAMETERS
//  DATA_WIDTH      32  word width, equal to the channel's DATA_WIDTH
//  LOG_DEPTH       5   width of pop_dw; BATCH_SIZE < 2**LOG_DEPTH
//  BATCH_SIZE      4   words per full batch, >=1
//  TIMEOUT         64  idle cycles with pop_dw!=0 before a partial batch is forced, >=1
//  OBUF_LOG_DEPTH  2   log2 of output buffer entries (4 entries)
// PORTS
//  clk          in   1               single clock, all logic posedge
//  reset        in   1               synchronous, active-high
//  pop_enable   out  1               pop request to channel
//  pop_valid    in   1               channel data valid (1 cycle after pop_enable & ~pop_empty)
//  pop_data     in   DATA_WIDTH      channel read data, qualified by pop_valid
//  pop_dw       in   LOG_DEPTH       channel fill level
//  pop_empty    in   1               channel empty
//  flush        in   1               force immediate partial batch
//  out_valid    out  1               stream word available
//  out_data     out  DATA_WIDTH      stream word
//  out_last     out  1               final word of current batch
//  out_ready    in   1               downstream accepts
//  batch_count  out  16              completed batches, wraps at 2**16
//  error        out  1               sticky protocol error
// BEHAVIOUR
//  Reset: state IDLE, obuf empty, timer=0, in-flight=0, remaining=0; out_valid=0, out_last=0, batch_count=0, error=0.
//  pop_enable is forced 0 while reset=1. pop_valid during reset is ignored.
//  pop_enable = (state==DRAIN) & remaining!=0 & ~pop_empty & (obuf_count + inflight) < 2**OBUF_LOG_DEPTH.
//  inflight is a register: it is set to pop_enable each cycle, so it marks that a pop_valid is due next cycle.
//  IDLE:
//    - pop_dw >= BATCH_SIZE: go to DRAIN, remaining=BATCH_SIZE.
//    - Else pop_dw!=0 and (timer==TIMEOUT-1 or flush): go to DRAIN, remaining=pop_dw.
//    - Else pop_dw!=0: timer++.
//    - pop_dw==0: timer=0, and flush is ignored.
//  DRAIN: each pop_enable cycle decrements remaining. The pop that takes remaining 1->0 is tagged last; the tag is delayed with inflight.
//    - pop_empty while remaining!=0: stall, no pop, no error.
//    - flush in DRAIN: ignored.
//    - remaining==0 & inflight==0: go to IDLE, timer=0.
//  Obuf: FIFO of {last,data}, written on pop_valid, read on out_valid & out_ready. Same-cycle write+read allowed (count unchanged).
//  Stream: out_valid = obuf nonempty; out_data/out_last = head, held stable while out_valid & ~out_ready.
//  batch_count increments when a word with last=1 is transferred.
//  Latency: condition seen in IDLE at cycle N -> pop_enable N+1 -> pop_valid N+2 -> out_valid N+3.
//  Throughput: 1 word/cycle sustained when out_ready=1.
//  Credit rule guarantees no obuf overflow.
//  error set and held until reset by either:
//    - pop_valid with inflight==0
//    - obuf write while full
// TESTING
//  1 BATCH_SIZE=4, preload 0xA0..0xA3, out_ready=1 -> 4 consecutive pop_enable cycles.
//    Out A0,A1,A2,A3 in order, out_last only on A3, batch_count=1, error=0.
//  2 Preload 2 words, no flush, TIMEOUT=64 -> no pop_enable for the 63 cycles after first pop_dw!=0.
//    DRAIN on timeout, 2 words out, out_last on the 2nd.
//  3 out_ready=0, preload 8 words -> exactly 4 pops, then pop_enable=0.
//    Raise out_ready -> all 8 words in order as batches of 4; out_last on 4th and 8th; error=0.
//  4 1 word in channel, pulse flush -> DRAIN next cycle, single word out with out_last=1.
//  5 Drive pop_valid=1 with no preceding pop_enable -> error=1 next cycle, stays 1 until reset.
//  6 Assert reset mid-DRAIN with 2 words in obuf -> next cycle out_valid=0, pop_enable=0.
//    state IDLE, batch_count=0, error=0.

Source files
------------

// File: rtl/fifo_channel_batch_reader_if.sv
// Bundle of the channel pop side and the outgoing word stream for the batch reader.
//
// Handshake semantics:
//   Channel side: pop_enable requests one word; the channel answers with
//   pop_valid/pop_data exactly one cycle later (non-showahead). pop_dw and
//   pop_empty report the channel fill level.
//   Stream side: a word moves when out_valid & out_ready are both high on a
//   rising clk edge. Once out_valid is high, out_data/out_last stay stable and
//   out_valid stays high until that transfer happens. out_ready may depend on
//   out_valid; out_valid never depends on out_ready.
interface fifo_channel_batch_reader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int LOG_DEPTH  = 5
);
  logic                  pop_enable;
  logic                  pop_valid;
  logic [DATA_WIDTH-1:0] pop_data;
  logic [LOG_DEPTH-1:0]  pop_dw;
  logic                  pop_empty;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  out_ready;

  // Batch reader side
  modport master (
    output pop_enable, out_valid, out_data, out_last,
    input  pop_valid, pop_data, pop_dw, pop_empty, out_ready
  );

  // Channel + downstream consumer side
  modport slave (
    input  pop_enable, out_valid, out_data, out_last,
    output pop_valid, pop_data, pop_dw, pop_empty, out_ready
  );
endinterface

// File: rtl/fifo_channel_batch_reader.sv
// Batch reader for the pop side of an async FIFO channel. Waits for a full
// batch (or a timeout / flush with a partial batch), pops the words under
// credit control into a small output buffer and re-emits them on a
// valid/ready stream with the final word of each batch tagged last.
module fifo_channel_batch_reader #(
  parameter int DATA_WIDTH     = 32,
  parameter int LOG_DEPTH      = 5,
  parameter int BATCH_SIZE     = 4,
  parameter int TIMEOUT        = 64,
  parameter int OBUF_LOG_DEPTH = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  fifo_channel_batch_reader_if.master       bus,
  input  logic                              flush,
  output logic [15:0]                       batch_count,
  output logic                              error,
  output logic                              dbg_state
);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam int OBUF_DEPTH = 1 << OBUF_LOG_DEPTH;
  localparam int TW         = $clog2(TIMEOUT + 1);

  localparam logic [TW-1:0]               TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [LOG_DEPTH-1:0]        BATCH      = LOG_DEPTH'(BATCH_SIZE);
  localparam logic [OBUF_LOG_DEPTH:0]     OBUF_FULL  = (OBUF_LOG_DEPTH + 1)'(OBUF_DEPTH);
  localparam logic [OBUF_LOG_DEPTH+1:0]   OBUF_CAP   = (OBUF_LOG_DEPTH + 2)'(OBUF_DEPTH);

  state_t                  state;
  logic [LOG_DEPTH-1:0]    remaining;
  logic [TW-1:0]           timer;
  logic                    inflight;
  logic                    inflight_last;

  logic [DATA_WIDTH:0]     obuf_mem [OBUF_DEPTH];
  logic [OBUF_LOG_DEPTH-1:0] wr_ptr;
  logic [OBUF_LOG_DEPTH-1:0] rd_ptr;
  logic [OBUF_LOG_DEPTH:0]   obuf_count;

  logic                    pop_en;
  logic [OBUF_LOG_DEPTH+1:0] credit_used;
  logic                    obuf_full;
  logic                    obuf_wr;
  logic                    obuf_rd;
  logic                    obuf_wr_ok;
  logic                    out_valid_int;

  // A pop is only issued when its word is guaranteed a slot in the output
  // buffer, counting the word already on its way back from the channel.
  assign credit_used = {1'b0, obuf_count} + {{(OBUF_LOG_DEPTH + 1){1'b0}}, inflight};
  assign pop_en      = ~reset & (state == DRAIN) & (remaining != '0) &
                       ~bus.pop_empty & (credit_used < OBUF_CAP);

  assign obuf_full     = (obuf_count == OBUF_FULL);
  assign out_valid_int = (obuf_count != '0);
  assign obuf_wr       = bus.pop_valid;
  assign obuf_rd       = out_valid_int & bus.out_ready;
  // When full, a write is only safe if the head leaves in the same cycle.
  assign obuf_wr_ok    = obuf_wr & (~obuf_full | obuf_rd);

  assign bus.pop_enable = pop_en;
  assign bus.out_valid  = out_valid_int;
  assign bus.out_data   = obuf_mem[rd_ptr][DATA_WIDTH-1:0];
  assign bus.out_last   = out_valid_int & obuf_mem[rd_ptr][DATA_WIDTH];
  assign dbg_state      = state;

  // Batch FSM: decide when to drain, count down the batch, track the in-flight pop and its last tag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      remaining     <= '0;
      timer         <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= pop_en;
      inflight_last <= pop_en & (remaining == LOG_DEPTH'(1));
      case (state)
        IDLE: begin
          if (bus.pop_dw >= BATCH) begin
            state     <= DRAIN;
            remaining <= BATCH;
            timer     <= '0;
          end else if ((bus.pop_dw != '0) && ((timer == TIMER_LAST) || flush)) begin
            state     <= DRAIN;
            remaining <= bus.pop_dw;
            timer     <= '0;
          end else if (bus.pop_dw != '0) begin
            timer <= timer + TW'(1);
          end else begin
            timer <= '0;
          end
        end
        DRAIN: begin
          if (pop_en) begin
            remaining <= remaining - LOG_DEPTH'(1);
          end
          if ((remaining == '0) && !inflight) begin
            state <= IDLE;
            timer <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output buffer storage; contents are only meaningful where obuf_count says so.
  always_ff @(posedge clk) begin
    if (!reset && obuf_wr_ok) begin
      obuf_mem[wr_ptr] <= {inflight_last, bus.pop_data};
    end
  end

  // Output buffer pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      obuf_count <= '0;
    end else begin
      if (obuf_wr_ok) begin
        wr_ptr <= wr_ptr + OBUF_LOG_DEPTH'(1);
      end
      if (obuf_rd) begin
        rd_ptr <= rd_ptr + OBUF_LOG_DEPTH'(1);
      end
      if (obuf_wr_ok && !obuf_rd) begin
        obuf_count <= obuf_count + (OBUF_LOG_DEPTH + 1)'(1);
      end else if (!obuf_wr_ok && obuf_rd) begin
        obuf_count <= obuf_count - (OBUF_LOG_DEPTH + 1)'(1);
      end
    end
  end

  // Completed-batch counter and sticky protocol error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      batch_count <= '0;
      error       <= 1'b0;
    end else begin
      if (obuf_rd && bus.out_last) begin
        batch_count <= batch_count + 16'd1;
      end
      if ((bus.pop_valid && !inflight) || (obuf_wr && obuf_full && !obuf_rd)) begin
        error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_channel_batch_reader.sv
// Bench for fifo_channel_batch_reader: a behavioural channel model feeding the
// pop side, directed scenarios in the main process, and a stream monitor that
// checks every transferred word against the expected queue.
module tb_fifo_channel_batch_reader;

  localparam int W = 33;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [15:0] batch_count;
  logic        error;
  logic        dbg_state;

  fifo_channel_batch_reader_if #(.DATA_WIDTH(32), .LOG_DEPTH(5)) bus ();

  fifo_channel_batch_reader #(
    .DATA_WIDTH(32), .LOG_DEPTH(5), .BATCH_SIZE(4), .TIMEOUT(64), .OBUF_LOG_DEPTH(2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .flush       (flush),
    .batch_count (batch_count),
    .error       (error),
    .dbg_state   (dbg_state)
  );

  int          vectors    = 0;
  int          miscompares = 0;
  int          cyc        = 0;

  logic [31:0]  chan_q[$];
  logic [W-1:0] exp_q[$];
  int           pop_log[$];

  logic         inject;
  logic [31:0]  inject_data;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_word(input logic [31:0] data, input logic last);
    chan_q.push_back(data);
    exp_q.push_back({last, data});
  endtask

  task automatic wait_pops(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (pop_log.size() >= target) break;
      tick(1);
    end
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && chan_q.size() == 0 && dbg_state == 1'b0 && !bus.out_valid) break;
      tick(1);
    end
  endtask

  // ---------------- channel model (drives pop side at negedge) ----------------
  initial begin : channel_model
    logic        pending;
    logic [31:0] pending_data;
    pending      = 1'b0;
    pending_data = '0;
    bus.pop_valid = 1'b0;
    bus.pop_data  = '0;
    bus.pop_dw    = '0;
    bus.pop_empty = 1'b1;
    forever begin
      @(negedge clk);
      bus.pop_valid = pending | inject;
      bus.pop_data  = inject ? inject_data : pending_data;
      bus.pop_dw    = 5'(chan_q.size());
      bus.pop_empty = (chan_q.size() == 0);
      #1;
      pending = bus.pop_enable;
      if (pending) begin
        pending_data = chan_q.pop_front();
        pop_log.push_back(cyc);
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin : monitor
    logic [W-1:0] exp;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL mon_unexpected: got 0x%0h, expected no word", {bus.out_last, bus.out_data});
        end else begin
          exp = exp_q.pop_front();
          check("mon_word", {31'b0, bus.out_last, bus.out_data}, {31'b0, exp});
        end
      end
    end
  end

  // ---------------- directed scenarios ----------------
  initial begin : main
    int base;
    int push_cyc;
    int flush_cyc;

    reset         = 1'b1;
    flush         = 1'b0;
    inject        = 1'b0;
    inject_data   = '0;
    bus.out_ready = 1'b0;

    // Reset state
    tick(3);
    check("rst_out_valid",   bus.out_valid,  0);
    check("rst_out_last",    bus.out_last,   0);
    check("rst_pop_enable",  bus.pop_enable, 0);
    check("rst_batch_count", batch_count,    0);
    check("rst_error",       error,          0);
    check("rst_state",       dbg_state,      0);
    reset = 1'b0;
    tick(1);

    // 1: full batch A0..A3, consecutive pops, last on A3
    bus.out_ready = 1'b1;
    base     = pop_log.size();
    push_cyc = cyc;
    for (int i = 0; i < 4; i++) push_word(32'hA0 + 32'(i), i == 3);
    wait_pops(base + 4, 30);
    check("t1_pops", pop_log.size() - base, 4);
    if (pop_log.size() >= base + 4) begin
      check("t1_latency",     pop_log[base] - push_cyc, 1);
      check("t1_consecutive", pop_log[base + 3] - pop_log[base], 3);
    end
    wait_idle(50);
    check("t1_drained",     exp_q.size(), 0);
    check("t1_batch_count", batch_count,  1);
    check("t1_error",       error,        0);

    // 2: two words, partial batch forced by timeout
    base     = pop_log.size();
    push_cyc = cyc;
    push_word(32'hB0, 1'b0);
    push_word(32'hB1, 1'b1);
    wait_pops(base + 2, 200);
    check("t2_pops", pop_log.size() - base, 2);
    if (pop_log.size() >= base + 2) begin
      check("t2_timeout_delay", pop_log[base] - push_cyc, 64);
      check("t2_consecutive",   pop_log[base + 1] - pop_log[base], 1);
    end
    wait_idle(50);
    check("t2_drained",     exp_q.size(), 0);
    check("t2_batch_count", batch_count,  2);

    // 3: back-pressure, credit stops popping after the buffer fills
    bus.out_ready = 1'b0;
    base = pop_log.size();
    for (int i = 0; i < 8; i++) push_word(32'hC0 + 32'(i), (i == 3) || (i == 7));
    tick(20);
    check("t3_pops_stalled", pop_log.size() - base, 4);
    check("t3_pop_enable",   bus.pop_enable, 0);
    check("t3_out_valid",    bus.out_valid,  1);
    check("t3_error_mid",    error,          0);
    bus.out_ready = 1'b1;
    wait_idle(100);
    check("t3_pops_total",   pop_log.size() - base, 8);
    check("t3_drained",      exp_q.size(), 0);
    check("t3_batch_count",  batch_count,  4);
    check("t3_error",        error,        0);

    // 4: single word drained by flush
    base     = pop_log.size();
    push_word(32'hD0, 1'b1);
    tick(1);
    flush     = 1'b1;
    flush_cyc = cyc;
    tick(1);
    flush = 1'b0;
    check("t4_state_drain", dbg_state, 1);
    wait_pops(base + 1, 20);
    check("t4_pops", pop_log.size() - base, 1);
    if (pop_log.size() >= base + 1) begin
      check("t4_pop_after_flush", pop_log[base] - flush_cyc, 1);
    end
    wait_idle(50);
    check("t4_drained",     exp_q.size(), 0);
    check("t4_batch_count", batch_count,  5);

    // 5: pop_valid with no pop in flight -> sticky error
    check("t5_error_before", error, 0);
    inject      = 1'b1;
    inject_data = 32'hEE;
    exp_q.push_back({1'b0, 32'hEE});
    tick(1);
    inject = 1'b0;
    check("t5_error_set", error, 1);
    tick(5);
    check("t5_error_sticky", error, 1);
    wait_idle(20);
    check("t5_drained",     exp_q.size(), 0);
    check("t5_batch_count", batch_count,  5);

    // 6: reset in the middle of a drain with words in the buffer
    bus.out_ready = 1'b0;
    base = pop_log.size();
    for (int i = 0; i < 4; i++) chan_q.push_back(32'hF0 + 32'(i));
    wait_pops(base + 3, 30);
    check("t6_pops_before_reset", pop_log.size() - base, 3);
    check("t6_state_drain",       dbg_state,     1);
    check("t6_out_valid_before",  bus.out_valid, 1);
    reset = 1'b1;
    tick(1);
    check("t6_out_valid",   bus.out_valid,  0);
    check("t6_out_last",    bus.out_last,   0);
    check("t6_pop_enable",  bus.pop_enable, 0);
    check("t6_state_idle",  dbg_state,      0);
    check("t6_batch_count", batch_count,    0);
    check("t6_error",       error,          0);
    reset = 1'b0;
    tick(3);
    check("t6_error_after",      error,          0);
    check("t6_out_valid_after",  bus.out_valid,  0);
    check("t6_pop_enable_after", bus.pop_enable, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
